// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-zero constant, MDU defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_MDU_LAT     = 4;
  localparam int         MDU_CNT_W       = 4;   // holds MDU_LAT up to 15

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: stalls are expressed through pc_write/ifid_write/idex_bubble.
// Ports: master = pipeline side (drives hazard inputs), slave = controller side.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_memread;
  logic [4:0]       IDEX_rt;
  logic [4:0]       IFID_rs;
  logic [4:0]       IFID_rt;
  logic             IFID_mdu_start;
  logic             IFID_mdu_use;
  logic             branch_taken;
  logic             stat_clr;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output IDEX_memread, IDEX_rt, IFID_rs, IFID_rt, IFID_mdu_start, IFID_mdu_use,
           branch_taken, stat_clr,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, mdu_busy,
           stall_cycles
  );

  modport slave (
    input  IDEX_memread, IDEX_rt, IFID_rs, IFID_rt, IFID_mdu_start, IFID_mdu_use,
           branch_taken, stat_clr,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, mdu_busy,
           stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count updates on the edge after inc; clr wins over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst (async, active-high), inc, clr, cnt (W bits).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use and MDU-busy stalls, branch flushes, stall-cycle counter.
// Latency: stall/flush outputs are combinational in the same cycle; MDU busy window follows accept.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; a taken branch overrides any stall.
// Ports: clk, rst (async, active-high), hz (hazard_ctrl_if.slave).
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = DEF_MDU_LAT,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  hz_state_t              state, state_nxt;
  logic [MDU_CNT_W-1:0]   cnt, cnt_nxt;

  logic lu_haz;
  logic mdu_haz;
  logic stall;
  logic accept_mdu;
  logic [CNT_W-1:0] stall_cnt;

  // Load result is not available until after MEM, so forwarding cannot cover a
  // dependent instruction sitting in ID. $0 is never a real dependency.
  assign lu_haz = hz.IDEX_memread && (hz.IDEX_rt != REG_ZERO) &&
                  ((hz.IDEX_rt == hz.IFID_rs) || (hz.IDEX_rt == hz.IFID_rt));

  // A second mul/div would clobber HI/LO in flight, so it waits like mfhi/mflo.
  assign mdu_haz = (cnt != '0) && (hz.IFID_mdu_use || hz.IFID_mdu_start);

  // The ID instruction is discarded on a taken branch, so it must not stall.
  assign stall      = (lu_haz || mdu_haz) && !hz.branch_taken;
  assign accept_mdu = hz.IFID_mdu_start && !stall && !hz.branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (accept_mdu) begin
          state_nxt = MDU_WAIT;
          cnt_nxt   = MDU_CNT_W'(MDU_LAT);
        end
      end
      MDU_WAIT: begin
        // accept_mdu cannot fire here: mdu_start in ID is stalled while cnt!=0.
        cnt_nxt = cnt - 1'b1;
        if (cnt == MDU_CNT_W'(1)) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .clr (hz.stat_clr),
    .cnt (stall_cnt)
  );

  // Reset overrides the combinational outputs so the pipeline is frozen with
  // a nop in ID/EX for as long as rst is high.
  always_comb begin
    hz.pc_write    = 1'b0;
    hz.ifid_write  = 1'b0;
    hz.idex_bubble = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.mdu_busy    = 1'b0;
    if (!rst) begin
      hz.pc_write    = !stall;
      hz.ifid_write  = !stall;
      hz.idex_bubble = stall;
      hz.ifid_flush  = hz.branch_taken;
      hz.idex_flush  = hz.branch_taken;
      hz.mdu_busy    = (cnt != '0);
    end
  end

  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// Latency: checks combinational outputs 1ns after each rising edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .MDU_LAT (4),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.IDEX_memread   = 1'b0;
    hz.IDEX_rt        = 5'd0;
    hz.IFID_rs        = 5'd0;
    hz.IFID_rt        = 5'd0;
    hz.IFID_mdu_start = 1'b0;
    hz.IFID_mdu_use   = 1'b0;
    hz.branch_taken   = 1'b0;
    hz.stat_clr       = 1'b0;
  endtask

  task automatic load_use();
    hz.IDEX_memread = 1'b1;
    hz.IDEX_rt      = 5'd5;
    hz.IFID_rs      = 5'd5;
    hz.IFID_rt      = 5'd7;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rst = 1'b1;
    #12;
    // Reset state
    chk("rst_pc_write",    32'(hz.pc_write),     32'd0);
    chk("rst_ifid_write",  32'(hz.ifid_write),   32'd0);
    chk("rst_idex_bubble", 32'(hz.idex_bubble),  32'd1);
    chk("rst_ifid_flush",  32'(hz.ifid_flush),   32'd0);
    chk("rst_idex_flush",  32'(hz.idex_flush),   32'd0);
    chk("rst_mdu_busy",    32'(hz.mdu_busy),     32'd0);
    chk("rst_stall_cnt",   32'(hz.stall_cycles), 32'd0);
    #5;
    rst = 1'b0;
    step();
    chk("idle_pc_write",   32'(hz.pc_write),     32'd1);
    chk("idle_bubble",     32'(hz.idex_bubble),  32'd0);

    // Load-use: one-cycle stall
    load_use();
    #1;
    chk("lu_pc_write",     32'(hz.pc_write),     32'd0);
    chk("lu_ifid_write",   32'(hz.ifid_write),   32'd0);
    chk("lu_bubble",       32'(hz.idex_bubble),  32'd1);
    step();
    idle();                // load has moved to MEM
    #1;
    chk("lu_clear_pc",     32'(hz.pc_write),     32'd1);
    chk("lu_stall_cnt",    32'(hz.stall_cycles), 32'd1);

    // Load-use via rt operand
    hz.IDEX_memread = 1'b1;
    hz.IDEX_rt      = 5'd9;
    hz.IFID_rs      = 5'd3;
    hz.IFID_rt      = 5'd9;
    #1;
    chk("lu_rt_bubble",    32'(hz.idex_bubble),  32'd1);
    step();
    idle();
    #1;
    chk("lu_rt_stall_cnt", 32'(hz.stall_cycles), 32'd2);

    // Load to $0 never stalls
    hz.IDEX_memread = 1'b1;
    #1;
    chk("lz_pc_write",     32'(hz.pc_write),     32'd1);
    chk("lz_bubble",       32'(hz.idex_bubble),  32'd0);
    step();
    chk("lz_stall_cnt",    32'(hz.stall_cycles), 32'd2);
    idle();

    // MDU: mul accepted in T, mfhi in ID from T+1 stalls for 4 cycles
    hz.IFID_mdu_start = 1'b1;
    #1;
    chk("mdu_accept_pc",   32'(hz.pc_write),     32'd1);
    chk("mdu_busy_T",      32'(hz.mdu_busy),     32'd0);
    step();
    hz.IFID_mdu_start = 1'b0;
    hz.IFID_mdu_use   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mdu_busy_T%0d", i), 32'(hz.mdu_busy), 32'd1);
      chk($sformatf("mdu_stall_T%0d", i), 32'(hz.pc_write), 32'd0);
      step();
    end
    chk("mdu_busy_done",   32'(hz.mdu_busy),     32'd0);
    chk("mfhi_advance",    32'(hz.pc_write),     32'd1);
    chk("mdu_stall_cnt",   32'(hz.stall_cycles), 32'd6);
    step();
    idle();

    // Branch beats load-use
    load_use();
    hz.branch_taken = 1'b1;
    #1;
    chk("br_ifid_flush",   32'(hz.ifid_flush),   32'd1);
    chk("br_idex_flush",   32'(hz.idex_flush),   32'd1);
    chk("br_bubble",       32'(hz.idex_bubble),  32'd0);
    chk("br_pc_write",     32'(hz.pc_write),     32'd1);
    chk("br_ifid_write",   32'(hz.ifid_write),   32'd1);
    step();
    chk("br_stall_cnt",    32'(hz.stall_cycles), 32'd6);
    // Branch blocks MDU accept
    idle();
    hz.IFID_mdu_start = 1'b1;
    hz.branch_taken   = 1'b1;
    step();
    idle();
    #1;
    chk("br_mdu_no_busy",  32'(hz.mdu_busy),     32'd0);

    // Combined load-use + MDU hazard counts once per cycle
    hz.IFID_mdu_start = 1'b1;
    step();
    idle();
    load_use();
    hz.IFID_mdu_use = 1'b1;
    #1;
    chk("comb_bubble",     32'(hz.idex_bubble),  32'd1);
    step();
    chk("comb_stall_cnt",  32'(hz.stall_cycles), 32'd7);
    idle();
    // Drain the MDU window (3 remaining cycles)
    repeat (3) step();
    chk("comb_drained",    32'(hz.mdu_busy),     32'd0);

    // Async reset mid-MDU_WAIT
    hz.IFID_mdu_start = 1'b1;
    step();
    idle();
    step();                // now in T+2
    chk("ar_busy_before",  32'(hz.mdu_busy),     32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy_async",   32'(hz.mdu_busy),     32'd0);
    chk("ar_pc_write",     32'(hz.pc_write),     32'd0);
    chk("ar_stall_cnt",    32'(hz.stall_cycles), 32'd0);
    #1;
    rst = 1'b0;
    hz.IFID_mdu_use = 1'b1;
    #1;
    chk("ar_mfhi_free",    32'(hz.pc_write),     32'd1);
    step();
    chk("ar_mfhi_free2",   32'(hz.pc_write),     32'd1);
    chk("ar_busy_after",   32'(hz.mdu_busy),     32'd0);
    idle();

    // Saturation and clear
    load_use();
    hz.stat_clr = 1'b1;
    step();
    chk("clr_first",       32'(hz.stall_cycles), 32'd0);
    hz.stat_clr = 1'b0;
    repeat (65535 + 3) @(posedge clk);
    #1;
    chk("sat_hold",        32'(hz.stall_cycles), 32'h0000FFFF);
    step();
    chk("sat_hold2",       32'(hz.stall_cycles), 32'h0000FFFF);
    hz.stat_clr = 1'b1;
    step();
    chk("clr_over_stall",  32'(hz.stall_cycles), 32'd0);
    hz.stat_clr = 1'b0;
    step();
    chk("inc_after_clr",   32'(hz.stall_cycles), 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
